controlador_carga_ula: RTL

CONTROLADOR_CARGA_ULA -- requirements
Module: controlador_carga_ula

---
 rtl/controlador_carga_ula.sv | 123 ++++++++++++
 1 files changed

// File: rtl/controlador_carga_ula.sv
// Load sequencer for a two-operand ALU: latches opcode with operand A,
// loads operand B, waits for the ALU to settle, captures the result and
// holds it until the consumer takes it. Counts completed operations.
module controlador_carga_ula #(
  parameter int unsigned LAT_ULA = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [2:0] op_in,
  input  logic       cancela,
  output logic [7:0] reg_d,
  output logic       load_a,
  output logic       load_b,
  output logic       load_r,
  output logic [2:0] op_reg,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic [7:0] ops_count
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 3;
  localparam int unsigned CW  = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT_ULA - 1);

  typedef enum logic [2:0] {
    ESPERA_A = 3'd0,
    ESPERA_B = 3'd1,
    CALC     = 3'd2,
    CAPTURA  = 3'd3,
    ENTREGA  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [OPW-1:0]  op_q,    op_d;
  logic [DW-1:0]   ops_q,   ops_d;

  // State, wait counter, opcode latch and operation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ESPERA_A;
      cnt_q   <= '0;
      op_q    <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ops_q   <= ops_d;
    end
  end

  // Next state and load strobes; the strobes are combinational so the
  // operand registers capture on the same edge as the handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    ops_d    = ops_q;
    in_ready = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_r   = 1'b0;

    unique case (state_q)
      ESPERA_A: begin
        in_ready = ~cancela & rst;
        load_a   = in_valid & ~cancela & rst;
        if (load_a) begin
          op_d    = op_in;
          state_d = ESPERA_B;
        end
      end
      ESPERA_B: begin
        in_ready = ~cancela & rst;
        load_b   = in_valid & ~cancela & rst;
        if (load_b) begin
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = CAPTURA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CAPTURA: begin
        load_r  = 1'b1;
        state_d = ENTREGA;
      end
      ENTREGA: begin
        if (res_ready) begin
          ops_d   = ops_q + DW'(1);
          state_d = ESPERA_A;
        end
      end
      default: state_d = ESPERA_A;
    endcase

    // Abort wins over everything; the opcode latch is left untouched
    if (cancela) begin
      state_d = ESPERA_A;
      op_d    = op_q;
      ops_d   = ops_q;
      load_r  = 1'b0;
    end
  end

  // Status decoded directly from state so reset clears it immediately
  assign res_valid = (state_q == ENTREGA);
  assign busy      = (state_q != ESPERA_A);
  assign reg_d     = in_data;
  assign op_reg    = op_q;
  assign ops_count = ops_q;

endmodule
